// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = 8;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MC_ABORT = 2'd2
  } state_e;

  // Per-cycle stage-register control bundle driven by the controller
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic mc_start;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_DEFAULT = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    if_id_flush:   1'b0,
    id_ex_write:   1'b1,
    id_ex_bubble:  1'b0,
    ex_mem_bubble: 1'b0,
    mc_start:      1'b0
  };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             uses_rs1_i,
  input  logic             uses_rs2_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_memread_i,
  output logic             load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never written, so a load targeting it cannot create a hazard
  assign rs1_hit    = uses_rs1_i && (ex_rd_i == rs1_i);
  assign rs2_hit    = uses_rs2_i && (ex_rd_i == rs2_i);
  assign load_use_o = ex_memread_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: load-use bubble, branch flush, multi-cycle EX freeze.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] if_id_rs1,
  input  logic [REG_W-1:0] if_id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             id_ex_mc_op,
  input  logic             ex_branch_taken,
  input  logic             mc_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mc_start,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              load_use;
  stage_ctrl_t       ctrl;

  hazard_detect u_hazard (
    .rs1_i        (if_id_rs1),
    .rs2_i        (if_id_rs2),
    .uses_rs1_i   (id_uses_rs1),
    .uses_rs2_i   (id_uses_rs2),
    .ex_rd_i      (id_ex_rd),
    .ex_memread_i (id_ex_memread),
    .load_use_o   (load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next state and zero-latency stage controls
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    ctrl    = CTRL_DEFAULT;

    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else if (id_ex_mc_op) begin
          ctrl.mc_start      = 1'b1;
          ctrl.pc_write      = 1'b0;
          ctrl.if_id_write   = 1'b0;
          ctrl.id_ex_write   = 1'b0;
          ctrl.ex_mem_bubble = 1'b1;
          wait_d             = '0;
          state_d            = MC_BUSY;
        end else if (load_use) begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
        end
      end

      MC_BUSY: begin
        wait_d = wait_q + WAIT_W'(1);
        if (mc_done) begin
          // Release: result enters EX/MEM with every stage enabled
          state_d = RUN;
        end else begin
          ctrl.pc_write      = 1'b0;
          ctrl.if_id_write   = 1'b0;
          ctrl.id_ex_write   = 1'b0;
          ctrl.ex_mem_bubble = 1'b1;
          if (wait_q == WAIT_LAST) begin
            err_d   = 1'b1;
            state_d = MC_ABORT;
          end
        end
      end

      MC_ABORT: begin
        ctrl.id_ex_bubble  = 1'b1;
        ctrl.ex_mem_bubble = 1'b1;
        state_d            = RUN;
      end

      default: state_d = RUN;
    endcase

    if (reset) begin
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
      ctrl.mc_start     = 1'b0;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_write   = ctrl.id_ex_write;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign mc_start      = ctrl.mc_start;
  assign mc_error      = err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.pc_write) stall_q <= stall_q + CNT_W'(1);
      if ((state_q == RUN) && ex_branch_taken) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
